// File: rtl/seg_pipeline_sequencer_if.sv
// Stage-engine handshake bundle for seg_pipeline_sequencer: start/active pulses out,
// per-stage completion pulses back.
interface seg_pipeline_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    logic [NUM_STAGES-1:0] stage_start;
    logic [NUM_STAGES-1:0] stage_active;
    logic [NUM_STAGES-1:0] stage_done;

    modport master (
        output stage_start,
        output stage_active,
        input  stage_done
    );

    modport slave (
        input  stage_start,
        input  stage_active,
        output stage_done
    );
endinterface

// File: rtl/seg_pipeline_sequencer.sv
// Frame sequencer: chains NUM_STAGES stage engines with per-stage watchdog,
// free-running mode, abort and a completed-frame counter. All outputs registered.
module seg_pipeline_sequencer #(
    parameter int                   NUM_STAGES     = 3,
    parameter int                   TIMEOUT_W      = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = {TIMEOUT_W{1'b1}},
    parameter int                   FRAME_CNT_W    = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          continuous,
    input  logic                          abort,
    input  logic                          err_clear,
    seg_pipeline_sequencer_if.master      stg,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          aborted,
    output logic                          error,
    output logic [$clog2(NUM_STAGES):0]   err_stage,
    output logic [FRAME_CNT_W-1:0]        frame_count,
    output logic [1:0]                    state_o
);

    localparam int ES_W = $clog2(NUM_STAGES) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ES_W-1:0]        idx_q, idx_d;
    logic [TIMEOUT_W-1:0]   timer_q, timer_d;
    logic [NUM_STAGES-1:0]  start_d, active_d;
    logic                   busy_d, fdone_d, abort_d, err_d;
    logic [ES_W-1:0]        err_stage_d;
    logic [FRAME_CNT_W-1:0] fcnt_d;
    logic                   done_hit, last_stage, timeout_hit;

    // stage_active is already one-hot on idx in RUN, so it masks the done bits directly
    assign done_hit    = |(stg.stage_done & stg.stage_active);
    assign last_stage  = (idx_q == ES_W'(NUM_STAGES - 1));
    assign timeout_hit = (TIMEOUT_CYCLES != '0) &&
                         (timer_q == TIMEOUT_CYCLES - TIMEOUT_W'(1));
    assign state_o     = state_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        start_d     = '0;
        fdone_d     = 1'b0;
        abort_d     = 1'b0;
        err_d       = error;
        err_stage_d = err_stage;
        fcnt_d      = frame_count;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    timer_d = '0;
                    start_d = NUM_STAGES'(1);
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    abort_d = 1'b1;
                end else if (done_hit) begin
                    timer_d = '0;
                    if (last_stage) begin
                        fdone_d = 1'b1;
                        fcnt_d  = frame_count + FRAME_CNT_W'(1);
                        idx_d   = '0;
                        if (continuous) start_d = NUM_STAGES'(1);
                        else            state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + ES_W'(1);
                        start_d = stg.stage_active << 1;
                    end
                end else if (timeout_hit) begin
                    state_d     = S_ERROR;
                    err_d       = 1'b1;
                    err_stage_d = idx_q;
                end else begin
                    timer_d = timer_q + TIMEOUT_W'(1);
                end
            end
            S_ERROR: begin
                if (err_clear) begin
                    state_d     = S_IDLE;
                    idx_d       = '0;
                    err_d       = 1'b0;
                    err_stage_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d   = (state_d == S_RUN);
        active_d = (state_d == S_RUN) ? (NUM_STAGES'(1) << idx_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            idx_q            <= '0;
            timer_q          <= '0;
            stg.stage_start  <= '0;
            stg.stage_active <= '0;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
            aborted          <= 1'b0;
            error            <= 1'b0;
            err_stage        <= '0;
            frame_count      <= '0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            timer_q          <= timer_d;
            stg.stage_start  <= start_d;
            stg.stage_active <= active_d;
            busy             <= busy_d;
            frame_done       <= fdone_d;
            aborted          <= abort_d;
            error            <= err_d;
            err_stage        <= err_stage_d;
            frame_count      <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_seg_pipeline_sequencer.sv
// Directed bench for seg_pipeline_sequencer: spec-level model compared every cycle,
// plus literal checks at the scenario milestones.
module tb_seg_pipeline_sequencer;

    localparam int NS = 3;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset_n, start, continuous, abort, err_clear;
    logic       busy, frame_done, aborted, error;
    logic [2:0] err_stage;
    logic [15:0] frame_count;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    seg_pipeline_sequencer_if #(.NUM_STAGES(NS)) stg_if ();

    seg_pipeline_sequencer #(
        .NUM_STAGES(NS),
        .TIMEOUT_W(24),
        .TIMEOUT_CYCLES(24'd16),
        .FRAME_CNT_W(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .continuous(continuous),
        .abort(abort),
        .err_clear(err_clear),
        .stg(stg_if),
        .busy(busy),
        .frame_done(frame_done),
        .aborted(aborted),
        .error(error),
        .err_stage(err_stage),
        .frame_count(frame_count),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0=idle 1=run 2=error; elapsed = done-less cycles spent in current stage
    int m_mode = 0, m_stage = 0, m_elapsed = 0, m_frames = 0, m_errst = 0;
    int e_start = -1;
    bit e_fd = 0, e_ab = 0;

    always @(posedge clk) begin
        e_start = -1;
        e_fd    = 0;
        e_ab    = 0;
        if (!reset_n) begin
            m_mode = 0; m_stage = 0; m_elapsed = 0; m_frames = 0; m_errst = 0;
        end else if (m_mode == 0) begin
            if (start && !abort) begin
                m_mode = 1; m_stage = 0; m_elapsed = 0; e_start = 0;
            end
        end else if (m_mode == 1) begin
            if (abort) begin
                m_mode = 0; m_stage = 0; e_ab = 1;
            end else if (stg_if.stage_done[m_stage]) begin
                m_elapsed = 0;
                if (m_stage == NS - 1) begin
                    e_fd     = 1;
                    m_frames = (m_frames + 1) % 65536;
                    m_stage  = 0;
                    if (continuous) e_start = 0;
                    else            m_mode  = 0;
                end else begin
                    m_stage = m_stage + 1;
                    e_start = m_stage;
                end
            end else if (m_elapsed == TO - 1) begin
                m_mode = 2; m_errst = m_stage;
            end else begin
                m_elapsed++;
            end
        end else begin
            if (err_clear) begin
                m_mode = 0; m_errst = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("stage_start",  32'(stg_if.stage_start),  (e_start >= 0) ? (32'd1 << e_start) : 32'd0);
            chk("stage_active", 32'(stg_if.stage_active), (m_mode == 1) ? (32'd1 << m_stage) : 32'd0);
            chk("busy",         32'(busy),        32'(m_mode == 1));
            chk("frame_done",   32'(frame_done),  32'(e_fd));
            chk("aborted",      32'(aborted),     32'(e_ab));
            chk("error",        32'(error),       32'(m_mode == 2));
            chk("err_stage",    32'(err_stage),   32'(m_errst));
            chk("frame_count",  32'(frame_count), 32'(m_frames));
            chk("state_o",      32'(state_o),     32'(m_mode));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Called just after the edge that raised stage_start[s]; done is sampled lat edges later
    task automatic run_stage(input int s, input int lat);
        repeat (lat - 1) cyc();
        stg_if.stage_done[s] = 1'b1;
        cyc();
        stg_if.stage_done = '0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0; err_clear = 1'b0;
        stg_if.stage_done = '0;
        cyc();
        check_en = 1'b1;
        cyc();
        reset_n = 1'b1;
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_fcnt",  32'(frame_count), 32'd0);

        // 1. single shot
        do_start();
        chk("t1_start0", 32'(stg_if.stage_start), 32'b001);
        run_stage(0, 5);
        chk("t1_start1", 32'(stg_if.stage_start), 32'b010);
        run_stage(1, 5);
        chk("t1_start2", 32'(stg_if.stage_start), 32'b100);
        run_stage(2, 5);
        chk("t1_fdone", 32'(frame_done), 32'd1);
        chk("t1_fcnt",  32'(frame_count), 32'd1);
        chk("t1_idle",  32'(state_o), 32'd0);

        // 2. continuous, from a fresh reset
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        continuous = 1'b1;
        do_start();
        for (int f = 0; f < 4; f++) begin
            if (f == 3) continuous = 1'b0;
            for (int s = 0; s < NS; s++) run_stage(s, 5);
            if (f == 0) begin
                chk("t2_fdone_restart", 32'(frame_done), 32'd1);
                chk("t2_restart_start", 32'(stg_if.stage_start), 32'b001);
            end
        end
        chk("t2_fcnt", 32'(frame_count), 32'd4);
        chk("t2_idle", 32'(state_o), 32'd0);

        // 3. watchdog on stage 1
        do_start();
        run_stage(0, 5);
        repeat (TO - 1) cyc();
        chk("t3_no_err_yet", 32'(error), 32'd0);
        cyc();
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_err_stage", 32'(err_stage), 32'd1);
        start = 1'b1; abort = 1'b1;
        repeat (3) cyc();
        start = 1'b0; abort = 1'b0;
        chk("t3_held", 32'(state_o), 32'd2);
        err_clear = 1'b1;
        cyc();
        err_clear = 1'b0;
        chk("t3_cleared", 32'(state_o), 32'd0);
        chk("t3_errst_clr", 32'(err_stage), 32'd0);

        // abort beats start in IDLE
        start = 1'b1; abort = 1'b1;
        cyc();
        start = 1'b0; abort = 1'b0;
        chk("idle_abort_prio", 32'(state_o), 32'd0);

        // 4. abort together with last-stage done
        do_start();
        run_stage(0, 3);
        run_stage(1, 3);
        cyc();
        abort = 1'b1;
        stg_if.stage_done[2] = 1'b1;
        cyc();
        abort = 1'b0;
        stg_if.stage_done = '0;
        chk("t4_aborted", 32'(aborted), 32'd1);
        chk("t4_no_fdone", 32'(frame_done), 32'd0);
        chk("t4_fcnt", 32'(frame_count), 32'd4);

        // 5. stray done bit while stage 0 active
        do_start();
        cyc();
        stg_if.stage_done[2] = 1'b1;
        cyc();
        stg_if.stage_done = '0;
        chk("t5_active", 32'(stg_if.stage_active), 32'b001);
        chk("t5_no_fdone", 32'(frame_done), 32'd0);
        run_stage(0, 2);
        run_stage(1, 2);
        run_stage(2, 2);
        chk("t5_fcnt", 32'(frame_count), 32'd5);

        // 6. reset during stage 1
        do_start();
        run_stage(0, 3);
        cyc();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk("t6_active", 32'(stg_if.stage_active), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_fcnt", 32'(frame_count), 32'd0);
        chk("t6_aborted", 32'(aborted), 32'd0);
        do_start();
        chk("t6_restart", 32'(stg_if.stage_start), 32'b001);
        run_stage(0, 2);
        run_stage(1, 2);
        run_stage(2, 2);
        chk("t6_fcnt_after", 32'(frame_count), 32'd1);

        repeat (3) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
